// File: rtl/wim_pkg.sv
// rtl/wim_pkg.sv - shared window-invalid-mask constants and window index helpers
package wim_pkg;

   localparam int          NWINDOWS_DEF  = 4;
   localparam logic [31:0] RESET_WIM_DEF = 32'h0000_0008;

   // Bits [nw-1:0] set; a 33-bit intermediate keeps nw=32 from overflowing.
   function automatic logic [31:0] valid_mask(input int nw);
      logic [32:0] m;
      m = (33'd1 << nw) - 33'd1;
      return m[31:0];
   endfunction

   function automatic logic [4:0] next_win(input logic [4:0] w, input int nw);
      return (int'(w) == nw - 1) ? 5'd0 : w + 5'd1;
   endfunction

   function automatic logic [4:0] prev_win(input logic [4:0] w, input int nw);
      return (w == 5'd0) ? 5'(nw - 1) : w - 5'd1;
   endfunction

endpackage

// File: rtl/wim_unit_if.sv
// rtl/wim_unit_if.sv - check/load bus between the trap/PSR logic and the WIM block
interface wim_unit_if;

   logic        overFlow;
   logic        underFlow;
   logic [31:0] wimReg;
   logic [31:0] cwp;
   logic [31:0] wimIn;
   logic        bitDir;
   logic        enable;
   logic        wimLd;

   modport master (
      output cwp, wimIn, bitDir, enable, wimLd,
      input  overFlow, underFlow, wimReg
   );

   modport slave (
      input  cwp, wimIn, bitDir, enable, wimLd,
      output overFlow, underFlow, wimReg
   );

endinterface

// File: rtl/wim_win_index.sv
// rtl/wim_win_index.sv - cwp to current/next/previous window index, with modulo wrap
module wim_win_index
   import wim_pkg::*;
#(
   parameter int NWINDOWS = NWINDOWS_DEF
) (
   input  logic [31:0] cwp,
   output logic [4:0]  w,
   output logic [4:0]  nxt,
   output logic [4:0]  prv
);

   assign w   = 5'(cwp % 32'(NWINDOWS));
   assign nxt = next_win(w, NWINDOWS);
   assign prv = prev_win(w, NWINDOWS);

endmodule

// File: rtl/wim_unit.sv
// rtl/wim_unit.sv - WIM register with combinational SAVE/RESTORE invalid-window flags
module wim_unit
   import wim_pkg::*;
#(
   parameter int          NWINDOWS  = NWINDOWS_DEF,
   parameter logic [31:0] RESET_WIM = RESET_WIM_DEF
) (
   input logic        Clk,
   input logic        Clr,
   wim_unit_if.slave  bus
);

   localparam logic [31:0] WIM_MASK = valid_mask(NWINDOWS);

   logic [31:0] wimQ;
   logic [4:0]  unusedWin;
   logic [4:0]  nxtWin;
   logic [4:0]  prvWin;

   wim_win_index #(.NWINDOWS(NWINDOWS)) uIndex (
      .cwp (bus.cwp),
      .w   (unusedWin),
      .nxt (nxtWin),
      .prv (prvWin)
   );

   always_ff @(posedge Clk or posedge Clr) begin
      if (Clr) begin
         wimQ <= RESET_WIM & WIM_MASK;
      end else if (bus.wimLd) begin
         wimQ <= bus.wimIn & WIM_MASK;
      end
   end

   // Flags are held low during reset even though the reset WIM may have bits set.
   assign bus.overFlow  = ~Clr & bus.enable &  bus.bitDir & wimQ[nxtWin];
   assign bus.underFlow = ~Clr & bus.enable & ~bus.bitDir & wimQ[prvWin];
   assign bus.wimReg    = wimQ;

endmodule

// File: tb/tb_wim_unit.sv
// tb/tb_wim_unit.sv - scoreboard bench for wim_unit with NWINDOWS=4
module tb_wim_unit;

   typedef struct {
      string       tag;
      logic [31:0] wim;
      logic        ovf;
      logic        unf;
   } expT;

   logic        Clk;
   logic        Clr;
   logic [31:0] modelWim;
   expT         sbQ[$];
   int          nCompared   = 0;
   int          nMismatched = 0;

   wim_unit_if bus();

   wim_unit #(.NWINDOWS(4), .RESET_WIM(32'h0000_0008)) dut (
      .Clk (Clk),
      .Clr (Clr),
      .bus (bus)
   );

   initial begin
      Clk = 1'b0;
      #2;
      forever #5 Clk = ~Clk;
   end

   task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nCompared++;
      if (obs !== exp) begin
         nMismatched++;
         $display("FAIL %s: got %h, expected %h", tag, obs, exp);
      end
   endtask

   task automatic driveCheck(input string tag, input logic [31:0] c, input logic dir, input logic en);
      int  w;
      int  nxt;
      int  prv;
      expT e;
      bus.cwp    = c;
      bus.bitDir = dir;
      bus.enable = en;
      w   = int'(c % 32'd4);
      nxt = (w + 1) % 4;
      prv = (w + 3) % 4;
      e.tag = tag;
      e.wim = modelWim;
      e.ovf = !Clr && en && dir && modelWim[nxt];
      e.unf = !Clr && en && !dir && modelWim[prv];
      sbQ.push_back(e);
   endtask

   task automatic sampleCheck();
      expT e;
      #1;
      if (sbQ.size() == 0) begin
         nCompared++;
         nMismatched++;
         $display("FAIL scoreboard: got empty queue, expected an entry");
      end else begin
         e = sbQ.pop_front();
         checkVal({e.tag, " wimReg"}, bus.wimReg, e.wim);
         checkVal({e.tag, " overFlow"}, {31'b0, bus.overFlow}, {31'b0, e.ovf});
         checkVal({e.tag, " underFlow"}, {31'b0, bus.underFlow}, {31'b0, e.unf});
      end
   endtask

   initial begin
      Clr        = 1'b1;
      bus.wimLd  = 1'b0;
      bus.wimIn  = 32'h0;
      bus.enable = 1'b0;
      bus.bitDir = 1'b0;
      bus.cwp    = 32'h0;
      modelWim   = 32'h0000_0008;

      #1;
      driveCheck("reset", 32'd2, 1'b1, 1'b0);
      sampleCheck();
      driveCheck("reset en", 32'd2, 1'b1, 1'b1);
      sampleCheck();
      #2 Clr = 1'b0;
      #1;

      for (int c = 0; c <= 4; c++) begin
         driveCheck($sformatf("save cwp%0d", c), 32'(c), 1'b1, 1'b1);
         sampleCheck();
      end
      for (int c = 0; c <= 3; c++) begin
         driveCheck($sformatf("restore cwp%0d", c), 32'(c), 1'b0, 1'b1);
         sampleCheck();
      end
      driveCheck("gate", 32'd2, 1'b1, 1'b0);
      sampleCheck();

      // Load and check in the same cycle: flags must reflect the old WIM.
      @(negedge Clk);
      bus.wimIn = 32'hFFFF_FFF1;
      bus.wimLd = 1'b1;
      driveCheck("ld+save", 32'd2, 1'b1, 1'b1);
      sampleCheck();
      @(posedge Clk);
      #1;
      bus.wimLd = 1'b0;
      modelWim  = 32'h0000_0001;
      driveCheck("loaded save cwp3", 32'd3, 1'b1, 1'b1);
      sampleCheck();
      driveCheck("loaded restore cwp1", 32'd1, 1'b0, 1'b1);
      sampleCheck();
      driveCheck("loaded save cwp0", 32'd0, 1'b1, 1'b1);
      sampleCheck();
      driveCheck("loaded save cwp7", 32'd7, 1'b1, 1'b1);
      sampleCheck();

      @(negedge Clk);
      #2;
      Clr      = 1'b1;
      modelWim = 32'h0000_0008;
      driveCheck("async clr", 32'd3, 1'b1, 1'b1);
      sampleCheck();
      bus.wimIn = 32'hFFFF_FFFF;
      bus.wimLd = 1'b1;
      @(posedge Clk);
      #1;
      driveCheck("clr+ld", 32'd0, 1'b0, 1'b0);
      sampleCheck();
      @(negedge Clk);
      Clr       = 1'b0;
      bus.wimLd = 1'b0;
      driveCheck("after clr save cwp2", 32'd2, 1'b1, 1'b1);
      sampleCheck();
      driveCheck("after clr restore cwp0", 32'd0, 1'b0, 1'b1);
      sampleCheck();

      checkVal("queue drained", 32'(sbQ.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
